// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event controller: merges E0/F0 prefixes with the following scan byte
// into whole key events and queues them in a show-ahead FIFO. It also runs a
// prefix-timeout watchdog, keeps a saturating error count and a sticky overflow flag.
module ps2_key_event_ctrl #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic       Clock50,
   input  logic       iReset,
   input  logic [7:0] iByte,
   input  logic       iByteValid,
   input  logic       iFrameError,
   input  logic       iEvAck,
   input  logic       iClearErr,
   output logic       oEvValid,
   output logic [7:0] oKey,
   output logic       oRelease,
   output logic       oExtended,
   output logic       oFull,
   output logic       oOverflow,
   output logic [7:0] oErrCount
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          timeout;
   logic          push, pop, drop, wr, err;
   logic [9:0]    push_data;          // {extended, release, key}
   logic [9:0]    mem_q [DEPTH];
   logic [AW:0]   wptr_q, rptr_q;     // extra MSB distinguishes full from empty
   logic          empty, full;
   logic [9:0]    head;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          ovf_q, ovf_d;

   // Watchdog fires only when a prefix has waited the full budget and no byte arrives now.
   assign timeout = (state_q != StIdle) && !iByteValid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Prefix tracking FSM: decides next state, what to push and whether an error occurred.
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_data = 10'd0;
      err       = 1'b0;
      if (iByteValid) begin
         if (iFrameError) begin
            err     = 1'b1;
            state_d = StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  unique case (iByte)
                     8'hE0: state_d = StExt;
                     8'hF0: state_d = StBrk;
                     8'h00, 8'hFF: err = 1'b1;
                     8'hAA, 8'hFA, 8'hEE, 8'hFE: ;   // keyboard status replies, not key events
                     default: begin
                        push      = 1'b1;
                        push_data = {2'b00, iByte};
                     end
                  endcase
               end
               StExt: begin
                  if (iByte == 8'hF0) begin
                     state_d = StExtBrk;
                  end else if (iByte != 8'hE0) begin
                     push      = 1'b1;
                     push_data = {2'b10, iByte};
                     state_d   = StIdle;
                  end
               end
               StBrk: begin
                  state_d = StIdle;
                  if (iByte == 8'hE0 || iByte == 8'hF0) begin
                     err = 1'b1;
                  end else begin
                     push      = 1'b1;
                     push_data = {2'b01, iByte};
                  end
               end
               StExtBrk: begin
                  state_d = StIdle;
                  if (iByte == 8'hE0 || iByte == 8'hF0) begin
                     err = 1'b1;
                  end else begin
                     push      = 1'b1;
                     push_data = {2'b11, iByte};
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end else if (timeout) begin
         err     = 1'b1;
         state_d = StIdle;
      end
   end

   // Watchdog counter runs only while a prefix waits for its follow-up byte.
   always_comb begin
      tmo_d = tmo_q + TW'(1);
      if (iByteValid || state_q == StIdle) begin
         tmo_d = '0;
      end
   end

   // FIFO status and handshake.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop   = !empty && iEvAck;
   assign drop  = push && full && !pop;
   assign wr    = push && !drop;
   assign head  = mem_q[rptr_q[AW-1:0]];

   // Error counter saturates; a clear coinciding with an error leaves a count of one.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (iClearErr) begin
         err_cnt_d = err ? 8'd1 : 8'd0;
      end else if (err && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      ovf_d = iClearErr ? drop : (ovf_q | drop);
   end

   // State, watchdog, pointers and status registers.
   always_ff @(posedge Clock50 or posedge iReset) begin
      if (iReset) begin
         state_q   <= StIdle;
         tmo_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         err_cnt_q <= 8'd0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         err_cnt_q <= err_cnt_d;
         ovf_q     <= ovf_d;
         if (wr) begin
            wptr_q <= wptr_q + PtrOne;
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrOne;
         end
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge Clock50) begin
      if (wr) begin
         mem_q[wptr_q[AW-1:0]] <= push_data;
      end
   end

   assign oEvValid  = !empty;
   assign oKey      = empty ? 8'd0 : head[7:0];
   assign oRelease  = !empty && head[8];
   assign oExtended = !empty && head[9];
   assign oFull     = full;
   assign oOverflow = ovf_q;
   assign oErrCount = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: inputs change on the falling edge,
// outputs are checked on the falling edge after the capturing rising edge.
module tb_ps2_key_event_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 40;

   logic       Clock50 = 1'b0;
   logic       iReset;
   logic [7:0] iByte;
   logic       iByteValid, iFrameError, iEvAck, iClearErr;
   logic       oEvValid, oRelease, oExtended, oFull, oOverflow;
   logic [7:0] oKey, oErrCount;

   int vectors = 0;
   int miscompares = 0;

   ps2_key_event_ctrl #(
      .DEPTH         (DEPTH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clock50    (Clock50),
      .iReset     (iReset),
      .iByte      (iByte),
      .iByteValid (iByteValid),
      .iFrameError(iFrameError),
      .iEvAck     (iEvAck),
      .iClearErr  (iClearErr),
      .oEvValid   (oEvValid),
      .oKey       (oKey),
      .oRelease   (oRelease),
      .oExtended  (oExtended),
      .oFull      (oFull),
      .oOverflow  (oOverflow),
      .oErrCount  (oErrCount)
   );

   initial forever #5 Clock50 = ~Clock50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle strobe; returns at the falling edge of cycle n+1.
   task automatic strobe(input logic [7:0] b, input logic fe = 1'b0);
      @(negedge Clock50);
      iByte = b; iFrameError = fe; iByteValid = 1'b1;
      @(negedge Clock50);
      iByteValid = 1'b0; iFrameError = 1'b0;
   endtask

   task automatic ack();
      @(negedge Clock50);
      iEvAck = 1'b1;
      @(negedge Clock50);
      iEvAck = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [7:0] key, input logic rel,
                             input logic ext);
      check({tag, ".valid"}, 32'(oEvValid), 32'd1);
      check({tag, ".key"}, 32'(oKey), 32'(key));
      check({tag, ".rel"}, 32'(oRelease), 32'(rel));
      check({tag, ".ext"}, 32'(oExtended), 32'(ext));
   endtask

   initial begin
      iReset = 1'b1; iByte = 8'h00; iByteValid = 1'b0; iFrameError = 1'b0;
      iEvAck = 1'b0; iClearErr = 1'b0;
      repeat (3) @(negedge Clock50);
      check("rst.valid", 32'(oEvValid), 32'd0);
      check("rst.key", 32'(oKey), 32'd0);
      check("rst.full", 32'(oFull), 32'd0);
      check("rst.ovf", 32'(oOverflow), 32'd0);
      check("rst.err", 32'(oErrCount), 32'd0);
      iReset = 1'b0;

      // Plain make code, visible the cycle after the strobe.
      strobe(8'h1C);
      check_head("t1", 8'h1C, 1'b0, 1'b0);
      ack();
      check("t1.popped", 32'(oEvValid), 32'd0);

      // Break and extended-break sequences, order preserved.
      strobe(8'hF0);
      check("t2.prefix_only", 32'(oEvValid), 32'd0);
      strobe(8'h1C);
      strobe(8'hE0);
      strobe(8'hF0);
      strobe(8'h75);
      check_head("t2a", 8'h1C, 1'b1, 1'b0);
      ack();
      check_head("t2b", 8'h75, 1'b1, 1'b1);
      ack();
      check("t2.empty", 32'(oEvValid), 32'd0);
      check("t2.err", 32'(oErrCount), 32'd0);

      // Back-to-back strobes on consecutive cycles.
      @(negedge Clock50);
      iByte = 8'h15; iByteValid = 1'b1;
      @(negedge Clock50);
      iByte = 8'h16;
      @(negedge Clock50);
      iByteValid = 1'b0;
      check_head("b2b.a", 8'h15, 1'b0, 1'b0);
      ack();
      check_head("b2b.b", 8'h16, 1'b0, 1'b0);
      ack();

      // Frame error aborts a pending E0.
      strobe(8'hE0);
      strobe(8'h6B, 1'b1);
      check("t3.noev", 32'(oEvValid), 32'd0);
      check("t3.err", 32'(oErrCount), 32'd1);
      strobe(8'h16);
      check_head("t3", 8'h16, 1'b0, 1'b0);
      ack();

      // 00 is an error, AA is dropped silently.
      strobe(8'h00);
      strobe(8'hAA);
      check("bad.noev", 32'(oEvValid), 32'd0);
      check("bad.err", 32'(oErrCount), 32'd2);

      // Prefix timeout.
      strobe(8'hE0);
      repeat (TMO - 5) @(negedge Clock50);
      check("t4.before", 32'(oErrCount), 32'd2);
      repeat (10) @(negedge Clock50);
      check("t4.after", 32'(oErrCount), 32'd3);
      strobe(8'h75);
      check_head("t4", 8'h75, 1'b0, 1'b0);
      ack();

      // F0 followed by E0 is a bad prefix.
      strobe(8'hF0);
      strobe(8'hE0);
      check("badpfx.noev", 32'(oEvValid), 32'd0);
      check("badpfx.err", 32'(oErrCount), 32'd4);

      // Overflow with five pushes into a four-entry FIFO.
      strobe(8'h15);
      strobe(8'h1D);
      strobe(8'h24);
      strobe(8'h2D);
      check("t5.full", 32'(oFull), 32'd1);
      check("t5.noovf", 32'(oOverflow), 32'd0);
      strobe(8'h2C);
      check("t5.ovf", 32'(oOverflow), 32'd1);
      @(negedge Clock50);
      iClearErr = 1'b1;
      @(negedge Clock50);
      iClearErr = 1'b0;
      check("t5.clr_ovf", 32'(oOverflow), 32'd0);
      check("t5.clr_err", 32'(oErrCount), 32'd0);
      check_head("t5.p0", 8'h15, 1'b0, 1'b0);
      ack();
      check_head("t5.p1", 8'h1D, 1'b0, 1'b0);
      ack();
      check_head("t5.p2", 8'h24, 1'b0, 1'b0);
      ack();
      check_head("t5.p3", 8'h2D, 1'b0, 1'b0);
      ack();
      check("t5.empty", 32'(oEvValid), 32'd0);
      check("t5.notfull", 32'(oFull), 32'd0);

      // Push and pop together while full: no drop, pointers wrap.
      strobe(8'h11);
      strobe(8'h12);
      strobe(8'h13);
      strobe(8'h14);
      @(negedge Clock50);
      iByte = 8'h33; iByteValid = 1'b1; iEvAck = 1'b1;
      @(negedge Clock50);
      iByteValid = 1'b0; iEvAck = 1'b0;
      check("pp.full", 32'(oFull), 32'd1);
      check("pp.ovf", 32'(oOverflow), 32'd0);
      check_head("pp.h0", 8'h12, 1'b0, 1'b0);
      ack();
      check_head("pp.h1", 8'h13, 1'b0, 1'b0);
      ack();
      check_head("pp.h2", 8'h14, 1'b0, 1'b0);
      ack();
      check_head("pp.h3", 8'h33, 1'b0, 1'b0);
      ack();
      check("pp.empty", 32'(oEvValid), 32'd0);

      // Clear in the same cycle as an error leaves a count of one.
      strobe(8'hFF);
      strobe(8'hFF);
      @(negedge Clock50);
      iByte = 8'h00; iByteValid = 1'b1; iClearErr = 1'b1;
      @(negedge Clock50);
      iByteValid = 1'b0; iClearErr = 1'b0;
      check("clr_err_same", 32'(oErrCount), 32'd1);

      // Saturation at 255.
      for (int i = 0; i < 260; i++) begin
         strobe(8'hFF);
      end
      check("sat", 32'(oErrCount), 32'd255);

      // Reset mid-sequence with a queued event.
      strobe(8'h1C);
      strobe(8'hE0);
      strobe(8'hF0);
      @(negedge Clock50);
      iReset = 1'b1;
      @(negedge Clock50);
      check("t6.valid", 32'(oEvValid), 32'd0);
      check("t6.key", 32'(oKey), 32'd0);
      check("t6.err", 32'(oErrCount), 32'd0);
      check("t6.ovf", 32'(oOverflow), 32'd0);
      iReset = 1'b0;
      strobe(8'h74);
      check_head("t6", 8'h74, 1'b0, 1'b0);
      ack();
      check("t6.empty", 32'(oEvValid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
